// File: rtl/alu_wide_seq_pkg.sv
// ============================================================================
// alu_wide_seq_pkg : opcodes shared with the 8-bit ALU and sequencer states.
// Revision 1.0
// ============================================================================
`default_nettype none

package alu_wide_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_LSH = 3'd1,
        OP_RSH = 3'd2,
        OP_XOR = 3'd3,
        OP_AND = 3'd4
    } op_mne;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

    localparam int OP_COUNT_W = 16;

    // Ops whose shift/carry bit ripples from the first pass into the second.
    function automatic logic op_chains(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_LSH) || (op == OP_RSH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_wide_seq.sv
// ============================================================================
// alu_wide_seq : issues one 2W-bit op as two passes through a W-bit ALU.
// Optional macro WIDE_SEQ_PERF_EN adds the op_count_o completion counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_op_i,
    input  logic [2*W-1:0]        req_a_i,
    input  logic [2*W-1:0]        req_b_i,
    input  logic                  req_cin_i,
    output logic [W-1:0]          alu_a_o,
    output logic [W-1:0]          alu_b_o,
    output logic [2:0]            alu_op_o,
    output logic                  alu_sc_in_o,
    input  logic [W-1:0]          alu_out_i,
    input  logic                  alu_sc_out_i,
    input  logic                  alu_zero_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [2*W-1:0]        rsp_result_o,
    output logic                  rsp_carry_o,
`ifdef WIDE_SEQ_PERF_EN
    output logic [OP_COUNT_W-1:0] op_count_o,
`endif
    output logic                  rsp_zero_o
);

    seq_state_t     state_q, state_d;
    logic [2:0]     op_q;
    logic [2*W-1:0] a_q, b_q;
    logic           cin_q;
    logic [W-1:0]   part_q;
    logic           sc_q, z1_q;
    logic           rsp_valid_q;
    logic [2*W-1:0] rsp_result_q;
    logic           rsp_carry_q, rsp_zero_q;

    logic w_accept, w_handshake, w_hi_first, w_chain, w_is_shift, w_sel_hi;

    assign w_accept    = req_valid_i && (state_q == ST_IDLE);
    assign w_handshake = rsp_valid_q && rsp_ready_i;
    assign w_hi_first  = (op_q == OP_RSH);
    assign w_chain     = op_chains(op_q);
    assign w_is_shift  = (op_q == OP_LSH) || (op_q == OP_RSH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_sel_hi    = 1'b0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_op_o    = '0;
        alu_sc_in_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) state_d = ST_FIRST;
            end
            ST_FIRST: begin
                state_d     = ST_SECOND;
                w_sel_hi    = w_hi_first;
                alu_op_o    = op_q;
                alu_sc_in_o = w_chain & cin_q;
            end
            ST_SECOND: begin
                state_d     = ST_DONE;
                w_sel_hi    = !w_hi_first;
                alu_op_o    = op_q;
                alu_sc_in_o = w_chain & sc_q;
            end
            ST_DONE: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q == ST_FIRST) || (state_q == ST_SECOND)) begin
            alu_a_o = w_sel_hi ? a_q[2*W-1:W] : a_q[W-1:0];
            if (!w_is_shift) alu_b_o = w_sel_hi ? b_q[2*W-1:W] : b_q[W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            part_q       <= '0;
            sc_q         <= 1'b0;
            z1_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                op_q  <= req_op_i;
                a_q   <= req_a_i;
                b_q   <= req_b_i;
                cin_q <= req_cin_i;
            end
            if (state_q == ST_FIRST) begin
                part_q <= alu_out_i;
                sc_q   <= alu_sc_out_i;
                z1_q   <= alu_zero_i;
            end
            if (state_q == ST_SECOND) begin
                // part_q holds whichever word the first pass produced.
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= w_hi_first ? {part_q, alu_out_i} : {alu_out_i, part_q};
                rsp_carry_q  <= w_chain & alu_sc_out_i;
                rsp_zero_q   <= z1_q & alu_zero_i;
            end else if (w_handshake) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef WIDE_SEQ_PERF_EN
    logic [OP_COUNT_W-1:0] op_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_count_q <= '0;
        end else if (w_handshake) begin
            op_count_q <= op_count_q + 1'b1;
        end
    end

    assign op_count_o = op_count_q;
`endif

    assign req_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_carry_o  = rsp_carry_q;
    assign rsp_zero_o   = rsp_zero_q;

endmodule

`default_nettype wire
